dice_roller: RTL and testbench
==============================

DICE_ROLLER -- requirements
Module: dice_roller

Interface
REQ-001 Parameter DEB_CYCLES, default 16: consecutive stable cycles required before a debounced button level changes.
REQ-002 clkin  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 btna  input  1  raw active-low roll button for player A; asynchronous to clkin.
REQ-005 btnb  input  1  raw active-low roll button for player B; asynchronous to clkin.
REQ-006 count  output  4  registered die face; 0 after reset, otherwise 1..6.
REQ-007 throwa  output  1  active-low one-cycle strobe marking a new player A roll on count.
REQ-008 throwb  output  1  active-low one-cycle strobe marking a new player B roll on count.
REQ-009 turn  output  1  player whose roll is accepted next: 0 = A, 1 = B.
REQ-010 busy  output  1  high while a roll is in progress (HELD or FIRE).

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer, then a debouncer whose output follows the synchronized level only after DEB_CYCLES consecutive equal samples.
REQ-012 The face generator SHALL advance every clock while out of reset, independent of the FSM: sequence 1,2,3,4,5,6,1,...; reset value 1.
REQ-013 The FSM SHALL have states IDLE, HELD and FIRE; reset state IDLE.
REQ-014 IDLE -> HELD on a falling edge of the debounced button of the turn player; the other player's button SHALL be ignored in every state.
REQ-015 HELD -> FIRE on a rising edge (release) of the same debounced button; otherwise stay in HELD indefinitely.
REQ-016 In the FIRE cycle, count SHALL equal the face value sampled on the release-detect cycle, and exactly one of throwa/throwb (the turn player's) SHALL be low.
REQ-017 FIRE -> IDLE unconditionally after one cycle; turn SHALL toggle on that same edge.
REQ-018 count SHALL hold its value from FIRE until the next FIRE, so the consumer can sample count in any cycle where its strobe is low.
REQ-019 throwa and throwb SHALL never both be low; each strobe SHALL be exactly one cycle wide per completed press/release.
REQ-020 Latency: the strobe SHALL assert on the first clock after the debounced release is detected.
REQ-021 Simultaneous presses: only the turn player's button affects the FSM; the other player's debouncer still tracks its input.
REQ-022 busy SHALL be high in HELD and FIRE and low in IDLE.

Reset
REQ-023 Reset asserted SHALL immediately force count=0, throwa=1, throwb=1, turn=0, busy=0, FSM=IDLE, debouncers=released (high), face=1.
REQ-024 Reset asserted during HELD or FIRE SHALL abort the roll; no strobe is produced for that press after deassertion.
REQ-025 After reset deassertion, a button already held low SHALL be treated as a new press only after it debounces low from the released state.

Configuration
REQ-026 Macro DICE_LFSR_EN: when defined, the face SHALL be derived from an 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset; advanced every clock) as (lfsr mod 6)+1; when undefined, the face SHALL be the plain 1..6 wrap counter of REQ-012.

Structure
REQ-027 Shared package dice_pkg SHALL hold: FACE_MIN=1, FACE_MAX=6, FSM state encodings, PLAYER_A/PLAYER_B constants, LFSR seed and tap constants.
REQ-028 Synchronizer plus debouncer SHALL be a sub-module btn_debounce, instantiated once per button; the FSM and face generator remain in dice_roller.

Verification (DEB_CYCLES=4, DICE_LFSR_EN undefined unless stated)
REQ-029 Reset asserted mid-run -> count=0, throwa=throwb=1, turn=0, busy=0 immediately, without waiting for a clock edge.
REQ-030 btna low for 10 cycles then high, with face=3 on the release-detect cycle -> count=3 with throwa low for 1 cycle; turn becomes 1; throwb stays 1.
REQ-031 btnb pulsed (low 10 cycles) while turn=0 -> no strobe, busy stays 0, turn stays 0; a following valid A roll completes normally.
REQ-032 btna glitch low for 3 cycles -> no HELD entry, no strobe; glitch low for 5 cycles then release -> exactly one throwa strobe.
REQ-033 Release timed so face=6 -> count=6; face generator shows 1 on the next cycle; count holds at 6 until the next FIRE.
REQ-034 Reset pulsed during HELD, then btna released -> no strobe; with DICE_LFSR_EN defined, face sequence after reset SHALL match the reference LFSR model starting from seed 8'hA5.

Source files
------------

// File: rtl/dice_pkg.sv
// dice_pkg: constants shared by the dice roller slice.
//   FACE_MIN/FACE_MAX : legal die face range.
//   state_t           : roll FSM states.
//   PLAYER_A/PLAYER_B : encoding of the turn output.
//   LFSR_SEED/TAPS    : 8-bit Fibonacci LFSR (taps 8,6,5,4) used when
//                       DICE_LFSR_EN is defined.
package dice_pkg;

  localparam logic [3:0] FACE_MIN = 4'd1;
  localparam logic [3:0] FACE_MAX = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_FIRE = 2'd2
  } state_t;

  localparam logic PLAYER_A = 1'b0;
  localparam logic PLAYER_B = 1'b1;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;  // bits 7,5,4,3 = taps 8,6,5,4

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer followed by a level debouncer.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_raw    : raw active-low button, asynchronous to clk
//   btn_db     : debounced level; changes only after DEB_CYCLES
//                consecutive synchronized samples disagree with it.
// Reset leaves the chain in the released (high) state.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_db
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]    sync_q, sync_d;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d = {sync_q[0], btn_raw};
    db_d   = db_q;
    cnt_d  = '0;
    // cnt counts consecutive disagreeing samples; any agreeing sample clears it.
    if (sync_q[1] != db_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        db_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      db_q   <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  assign btn_db = db_q;

endmodule

// File: rtl/dice_roller.sv
// dice_roller: two-player electronic die.
//   clkin      : sole clock
//   reset      : asynchronous active-low reset
//   btna, btnb : raw active-low roll buttons (asynchronous)
//   count      : registered face, 0 after reset, else 1..6
//   throwa/b   : active-low one-cycle strobes marking a new roll on count
//   turn       : player whose roll is accepted next (0 = A, 1 = B)
//   busy       : high while a roll is in progress (HELD or FIRE)
// Build option: define DICE_LFSR_EN to derive the face from an 8-bit LFSR
// (lfsr mod 6 + 1) instead of the free-running 1..6 counter.
module dice_roller
  import dice_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       btna,
  input  logic       btnb,
  output logic [3:0] count,
  output logic       throwa,
  output logic       throwb,
  output logic       turn,
  output logic       busy
);

  logic dba, dbb;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .clk(clkin), .rst_n(reset), .btn_raw(btna), .btn_db(dba)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .clk(clkin), .rst_n(reset), .btn_raw(btnb), .btn_db(dbb)
  );

  // Face generator: runs every clock regardless of the FSM.
  logic [3:0] face;

`ifdef DICE_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
    face   = 4'(lfsr_q % 8'd6) + FACE_MIN;
  end

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end
`else
  logic [3:0] face_q, face_d;

  always_comb begin
    face_d = (face_q == FACE_MAX) ? FACE_MIN : face_q + 4'd1;
    face   = face_q;
  end

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) face_q <= FACE_MIN;
    else        face_q <= face_d;
  end
`endif

  // Roll FSM: only the turn player's debounced button is looked at.
  state_t     state_q, state_d;
  logic       turn_q, turn_d;
  logic [3:0] count_q, count_d;
  logic       throwa_q, throwa_d;
  logic       throwb_q, throwb_d;
  logic       dba_prev_q, dba_prev_d;
  logic       dbb_prev_q, dbb_prev_d;
  logic       sel_db, sel_prev;

  always_comb begin
    dba_prev_d = dba;
    dbb_prev_d = dbb;
    sel_db     = (turn_q == PLAYER_B) ? dbb : dba;
    sel_prev   = (turn_q == PLAYER_B) ? dbb_prev_q : dba_prev_q;

    state_d = state_q;
    turn_d  = turn_q;
    count_d = count_q;

    unique case (state_q)
      ST_IDLE: if (sel_prev && !sel_db) state_d = ST_HELD;
      ST_HELD: begin
        if (!sel_prev && sel_db) begin
          state_d = ST_FIRE;
          count_d = face;  // face of the release-detect cycle
        end
      end
      ST_FIRE: begin
        state_d = ST_IDLE;
        turn_d  = ~turn_q;
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes are registered alongside count so both appear in FIRE.
    throwa_d = !((state_d == ST_FIRE) && (turn_q == PLAYER_A));
    throwb_d = !((state_d == ST_FIRE) && (turn_q == PLAYER_B));
  end

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      turn_q     <= PLAYER_A;
      count_q    <= '0;
      throwa_q   <= 1'b1;
      throwb_q   <= 1'b1;
      dba_prev_q <= 1'b1;
      dbb_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      turn_q     <= turn_d;
      count_q    <= count_d;
      throwa_q   <= throwa_d;
      throwb_q   <= throwb_d;
      dba_prev_q <= dba_prev_d;
      dbb_prev_q <= dbb_prev_d;
    end
  end

  assign count  = count_q;
  assign throwa = throwa_q;
  assign throwb = throwb_q;
  assign turn   = turn_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dice_roller.sv
// Self-checking bench for dice_roller (DEB_CYCLES = 4). A behavioural
// model predicts every output each cycle from the raw button history.
module tb_dice_roller;

  localparam int unsigned DEB = 4;

  logic       clkin  = 1'b0;
  logic       reset  = 1'b1;
  logic       btna   = 1'b1;
  logic       btnb   = 1'b1;
  logic [3:0] count;
  logic       throwa, throwb, turn, busy;

  int tests = 0;
  int fails = 0;

  dice_roller #(.DEB_CYCLES(DEB)) dut (
    .clkin(clkin), .reset(reset), .btna(btna), .btnb(btnb),
    .count(count), .throwa(throwa), .throwb(throwb), .turn(turn), .busy(busy)
  );

  always #5 clkin = ~clkin;

  // ---------------- reference model ----------------
  // ha/hb: raw level sampled at each rising edge, newest first.
  bit ha[$];
  bit hb[$];
  int m_db[2];
  int m_prev[2];
  int m_state;   // 0 waiting, 1 button held, 2 strobe cycle
  int m_turn;
  int m_count;
  int m_n;       // clock edges since reset
  int m_lfsr;
  int m_fb;

  function automatic int m_face();
`ifdef DICE_LFSR_EN
    return (m_lfsr % 6) + 1;
`else
    return (m_n % 6) + 1;
`endif
  endfunction

  // The synchronizer delays raw by two edges; the level flips once the last
  // DEB synchronized samples all disagree with it.
  function automatic int deb_next(input int db, input bit h[$]);
    for (int j = 2; j < int'(DEB) + 2; j++)
      if (int'(h[j]) == db) return db;
    return 1 - db;
  endfunction

  task automatic m_reset();
    ha.delete();
    hb.delete();
    for (int j = 0; j < int'(DEB) + 2; j++) begin
      ha.push_back(1'b1);
      hb.push_back(1'b1);
    end
    m_db[0] = 1; m_db[1] = 1;
    m_prev[0] = 1; m_prev[1] = 1;
    m_state = 0; m_turn = 0; m_count = 0; m_n = 0; m_lfsr = 'hA5;
  endtask

  always @(posedge clkin or negedge reset) begin
    if (!reset) begin
      m_reset();
    end else begin
      case (m_state)
        0: if (m_prev[m_turn] == 1 && m_db[m_turn] == 0) m_state = 1;
        1: if (m_prev[m_turn] == 0 && m_db[m_turn] == 1) begin
             m_state = 2;
             m_count = m_face();
           end
        default: begin
          m_state = 0;
          m_turn  = 1 - m_turn;
        end
      endcase
      ha.push_front(btna); void'(ha.pop_back());
      hb.push_front(btnb); void'(hb.pop_back());
      m_prev[0] = m_db[0];
      m_prev[1] = m_db[1];
      m_db[0] = deb_next(m_db[0], ha);
      m_db[1] = deb_next(m_db[1], hb);
      m_n++;
      m_fb   = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
      m_lfsr = ((m_lfsr << 1) | m_fb) & 'hFF;
    end
  end

  function automatic logic [7:0] exp_vec();
    logic fire;
    fire = (m_state == 2);
    return {4'(m_count), !(fire && m_turn == 0), !(fire && m_turn == 1),
            m_turn[0], (m_state != 0)};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {count, throwa, throwb, turn, busy};
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic apply_reset();
    @(negedge clkin);
    reset = 1'b0;
    btna  = 1'b1;
    btnb  = 1'b1;
    repeat (2) @(negedge clkin);
    reset = 1'b1;
  endtask

  // Press, hold, then release; with target != 0 the release is placed so the
  // release-detect cycle (DEB+2 edges later) carries that face.
  task automatic roll(input int player, input int hold, input int target);
    @(negedge clkin);
    if (player == 0) btna = 1'b0; else btnb = 1'b0;
    repeat (hold) @(negedge clkin);
    for (int i = 0; i < 6 && target != 0 &&
         ((m_face() - 1 + int'(DEB) + 2) % 6) + 1 != target; i++)
      @(negedge clkin);
    if (player == 0) btna = 1'b1; else btnb = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    tests++;
    if (dut_vec() !== 8'b0000_1100) begin
      fails++; $display("FAIL reset_state got %b want 00001100", dut_vec());
    end
    roll(0, 10, 0);
    repeat (12) @(negedge clkin);
    btnb = 1'b0;
    repeat (10) @(negedge clkin);
    tests++;
    if (dut_vec() !== exp_vec() || busy !== 1'b1 || turn !== 1'b1) begin
      fails++; $display("FAIL pre_reset_held got %b want %b", dut_vec(), exp_vec());
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if (dut_vec() !== 8'b0000_1100) begin
      fails++; $display("FAIL async_reset got %b want 00001100", dut_vec());
    end
    btnb = 1'b1;
    @(negedge clkin);
    reset = 1'b1;
  endtask

  task automatic test_single_roll();
    int na, nb, cap;
    na = 0; nb = 0; cap = 0;
    apply_reset();
    roll(0, 10, 3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clkin);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL single_roll cyc %0d got %b want %b", i, dut_vec(), exp_vec());
      end
      if (throwa === 1'b0) begin na++; cap = int'(count); end
      if (throwb === 1'b0) nb++;
    end
    tests++;
    if (na != 1 || nb != 0 || turn !== 1'b1) begin
      fails++; $display("FAIL single_roll_strobe got na=%0d nb=%0d turn=%b want 1 0 1", na, nb, turn);
    end
`ifndef DICE_LFSR_EN
    tests++;
    if (cap != 3) begin
      fails++; $display("FAIL single_roll_face got %0d want 3", cap);
    end
`endif
  endtask

  task automatic test_ignore_other();
    int bad, na;
    bad = 0; na = 0;
    apply_reset();
    btnb = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clkin);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL ignore_other cyc %0d got %b want %b", i, dut_vec(), exp_vec());
      end
      if (busy !== 1'b0 || turn !== 1'b0 || throwb !== 1'b1 || throwa !== 1'b1) bad++;
      btnb = (i < 9) ? 1'b0 : 1'b1;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL ignore_other_idle got %0d active cycles want 0", bad);
    end
    roll(0, 8, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clkin);
      if (throwa === 1'b0) na++;
    end
    tests++;
    if (na != 1 || turn !== 1'b1) begin
      fails++; $display("FAIL ignore_then_a got strobes=%0d turn=%b want 1 1", na, turn);
    end
  endtask

  task automatic test_glitch();
    int nbusy, na;
    nbusy = 0; na = 0;
    apply_reset();
    @(negedge clkin);
    btna = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clkin);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL glitch3 cyc %0d got %b want %b", i, dut_vec(), exp_vec());
      end
      if (busy !== 1'b0 || throwa !== 1'b1) nbusy++;
      btna = (i < 2) ? 1'b0 : 1'b1;
    end
    tests++;
    if (nbusy != 0) begin
      fails++; $display("FAIL glitch3_ignored got %0d active cycles want 0", nbusy);
    end
    @(negedge clkin);
    btna = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clkin);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL glitch5 cyc %0d got %b want %b", i, dut_vec(), exp_vec());
      end
      if (throwa === 1'b0) na++;
      btna = (i < 4) ? 1'b0 : 1'b1;
    end
    tests++;
    if (na != 1) begin
      fails++; $display("FAIL glitch5_strobe got %0d want 1", na);
    end
  endtask

  task automatic test_face6_hold();
    int seen, held_bad, cap_b, nb;
    seen = 0; held_bad = 0; cap_b = 0; nb = 0;
    apply_reset();
    roll(0, 8, 6);
    for (int i = 0; i < 40; i++) begin
      @(negedge clkin);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL face6 cyc %0d got %b want %b", i, dut_vec(), exp_vec());
      end
`ifndef DICE_LFSR_EN
      if (throwa === 1'b0) seen = 1;
      if (seen == 1 && count !== 4'd6) held_bad++;
`endif
    end
`ifndef DICE_LFSR_EN
    tests++;
    if (seen != 1 || held_bad != 0) begin
      fails++; $display("FAIL face6_hold got seen=%0d bad=%0d want 1 0", seen, held_bad);
    end
`endif
    roll(1, 8, 2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clkin);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL next_fire cyc %0d got %b want %b", i, dut_vec(), exp_vec());
      end
      if (throwb === 1'b0) begin nb++; cap_b = int'(count); end
    end
    tests++;
    if (nb != 1 || turn !== 1'b0) begin
      fails++; $display("FAIL next_fire_strobe got nb=%0d turn=%b want 1 0", nb, turn);
    end
`ifndef DICE_LFSR_EN
    tests++;
    if (cap_b != 2) begin
      fails++; $display("FAIL next_fire_face got %0d want 2", cap_b);
    end
`endif
  endtask

  task automatic test_reset_held();
    int strobes, na;
    strobes = 0; na = 0;
    apply_reset();
    @(negedge clkin);
    btna = 1'b0;
    repeat (10) @(negedge clkin);
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL held_entered got busy=%b want 1", busy);
    end
    #2 reset = 1'b0;
    btna = 1'b1;
    @(negedge clkin);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clkin);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL abort cyc %0d got %b want %b", i, dut_vec(), exp_vec());
      end
      if (throwa === 1'b0 || throwb === 1'b0 || busy === 1'b1) strobes++;
    end
    tests++;
    if (strobes != 0) begin
      fails++; $display("FAIL abort_no_strobe got %0d active cycles want 0", strobes);
    end
    // button held low across reset: must debounce from released first
    @(negedge clkin);
    reset = 1'b0;
    btna  = 1'b0;
    @(negedge clkin);
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clkin);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL held_thru_reset cyc %0d got %b want %b", i, dut_vec(), exp_vec());
      end
      if (throwa === 1'b0) na++;
      if (i == 14) btna = 1'b1;
    end
    tests++;
    if (na != 1) begin
      fails++; $display("FAIL held_thru_reset_strobe got %0d want 1", na);
    end
  endtask

  task automatic test_back_to_back();
    int na, nb;
    apply_reset();
    for (int r = 0; r < 4; r++) begin
      na = 0; nb = 0;
      roll(r % 2, 6, 0);
      for (int i = 0; i < 12; i++) begin
        @(negedge clkin);
        tests++;
        if (dut_vec() !== exp_vec()) begin
          fails++; $display("FAIL b2b r%0d cyc %0d got %b want %b", r, i, dut_vec(), exp_vec());
        end
        if (throwa === 1'b0) na++;
        if (throwb === 1'b0) nb++;
      end
      tests++;
      if (na != ((r % 2 == 0) ? 1 : 0) || nb != ((r % 2 == 1) ? 1 : 0) ||
          turn !== ((r % 2 == 0) ? 1'b1 : 1'b0)) begin
        fails++; $display("FAIL b2b_turn r%0d got na=%0d nb=%0d turn=%b", r, na, nb, turn);
      end
    end
  endtask

  task automatic test_random();
    int ra, rb, both, nstrobe;
    ra = 1; rb = 1; both = 0; nstrobe = 0;
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      @(negedge clkin);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL random cyc %0d got %b want %b", i, dut_vec(), exp_vec());
      end
      if (throwa === 1'b0 && throwb === 1'b0) both++;
      if (throwa === 1'b0 || throwb === 1'b0) nstrobe++;
      ra--; rb--;
      if (ra == 0) begin btna = ~btna; ra = int'($urandom_range(1, 14)); end
      if (rb == 0) begin btnb = ~btnb; rb = int'($urandom_range(1, 14)); end
    end
    tests++;
    if (both != 0 || nstrobe == 0) begin
      fails++; $display("FAIL random_strobes got both=%0d total=%0d want 0 >0", both, nstrobe);
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    test_reset();
    test_single_roll();
    test_ignore_other();
    test_glitch();
    test_face6_hold();
    test_reset_held();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
